// File: rtl/dmem_pkg.sv
// Shared constants and FSM state type for the data-memory responder.
// Width codes follow the RV32I load/store funct3 encoding.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MAX_WAIT_STATES = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and replication, load lane
// extraction with sign/zero extension, and width/alignment error detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        align_err
);

  logic [31:0] rword_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rword_shift = rword >> {addr_lo, 3'b000};
  assign byte_sel    = rword_shift[7:0];
  assign half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = 32'h0;
    align_err = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        align_err = write && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        align_err = addr_lo[0] || (write && (funct3 == F3_HU));
      end
      F3_W: begin
        byte_en   = 4'b1111;
        rdata_ext = rword;
        align_err = |addr_lo;
      end
      default: align_err = 1'b1;
    endcase
    // A rejected access must never touch the array.
    if (align_err) byte_en = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, WAIT_STATES busy
// cycles, one-cycle response strobe. Optional macro DMEM_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// BUSY  | counting wait states; access performed when counter reaches 0
// RESP  | rsp_valid high for one cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int WAIT_USE = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_USE);

`ifdef DMEM_RANGE_CHECK_EN
  localparam int CAP_W = 32;
`else
  localparam int CAP_W = ADDR_WIDTH + 2;
`endif

  dmem_state_e state_q, state_d;
  logic [2:0]       cnt_q;
  logic             write_q;
  logic [CAP_W-1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       funct3_q;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] rword;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        align_err;
  logic        range_err;
  logic        err_all;
  logic        accept;
  logic        done;
  logic        mem_we;

  assign idx   = addr_q[ADDR_WIDTH+1:2];
  assign rword = mem[idx];

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err = |addr_q[31:ADDR_WIDTH+2];
`else
  // Upper address bits alias; they are deliberately not captured.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];
  assign range_err      = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .write     (write_q),
    .wdata     (wdata_q),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .align_err (align_err)
  );

  assign err_all = align_err || range_err;
  assign accept  = req_valid && req_ready;
  assign done    = (state_q == BUSY) && (cnt_q == 3'd0);
  assign mem_we  = done && write_q && !err_all;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = reset;
        if (req_valid && reset) state_d = BUSY;
      end
      BUSY: if (cnt_q == 3'd0) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      funct3_q  <= 3'b000;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= WAIT_INIT;
        write_q  <= req_write;
        addr_q   <= req_addr[CAP_W-1:0];
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end else if ((state_q == BUSY) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (done) begin
        rsp_err   <= err_all;
        rsp_rdata <= (err_all || write_q) ? 32'h0 : rdata_ext;
      end
    end
  end

  // Array is not reset; reset during BUSY leaves state_q at IDLE so mem_we stays low.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses compared against a byte-array reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW = 10;
  localparam int WS = 1;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mref [4096];
  logic [31:0] got_rd;
  logic        got_err;

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte memory of 4 KiB, rules applied arithmetically.
  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int size;
    bit uns;
    int off;
    logic [31:0] v;
    size = 1; uns = 1'b0; err = 1'b0; rd = 32'h0;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1'b1; end
      3'd5: begin size = 2; uns = 1'b1; end
      default: err = 1'b1;
    endcase
    if (w && uns) err = 1'b1;
    if ((a % size) != 0) err = 1'b1;
    if (RANGE_CHECK && (a >= 32'd4096)) err = 1'b1;
    if (err) return;
    off = int'(a % 32'd4096);
    if (w) begin
      for (int i = 0; i < size; i++) mref[off+i] = 8'((d >> (8*i)) & 32'hFF);
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mref[off+i]) << (8*i));
      if (!uns && size == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!uns && size == 2 && v[15]) v = v | 32'hFFFF0000;
      rd = v;
    end
  endtask

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] exp_rd;
    logic        exp_err;
    int n;
    model(w, a, d, f3, exp_rd, exp_err);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3; req_valid = 1'b1;
    chk("ready_in_idle", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    // Hold valid high with a different store while busy; it must be ignored.
    req_write = 1'b1; req_funct3 = F3_W; req_wdata = $urandom;
    req_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
    chk("ready_low_busy", 32'(req_ready), 32'h0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin n = i; break; end
    end
    req_valid = 1'b0;
    if (n == 0) chk("rsp_timeout", 32'h0, 32'h1);
    else chk("rsp_latency", 32'(n), 32'(WS + 1));
    got_rd = rsp_rdata; got_err = rsp_err;
    chk("rsp_rdata_model", rsp_rdata, exp_rd);
    chk("rsp_err_model", 32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    chk("rsp_valid_one_cycle", 32'(rsp_valid), 32'h0);
    chk("rsp_rdata_hold", rsp_rdata, got_rd);
  endtask

  logic [2:0]  f3_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd1, 3'd3, 3'd7};
  logic [31:0] ra;

  initial begin
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    txn(1, 32'h0, 32'hCAFEF00D, F3_W);
    txn(1, 32'h10, 32'hDEADBEEF, F3_W);
    chk("sw10_err", 32'(got_err), 32'h0);
    txn(0, 32'h10, 32'h0, F3_W);
    chk("lw10_a", got_rd, 32'hDEADBEEF);

    txn(1, 32'h13, 32'h000000A5, F3_B);
    txn(0, 32'h13, 32'h0, F3_B);   chk("lb13", got_rd, 32'hFFFFFFA5);
    txn(0, 32'h13, 32'h0, F3_BU);  chk("lbu13", got_rd, 32'h000000A5);
    txn(0, 32'h10, 32'h0, F3_W);   chk("lw10_b", got_rd, 32'hA5ADBEEF);

    txn(1, 32'h10, 32'h00008001, F3_H);
    txn(0, 32'h10, 32'h0, F3_H);   chk("lh10", got_rd, 32'hFFFF8001);
    txn(0, 32'h10, 32'h0, F3_HU);  chk("lhu10", got_rd, 32'h00008001);
    txn(0, 32'h10, 32'h0, F3_W);   chk("lw10_c", got_rd, 32'hA5AD8001);

    txn(1, 32'h11, 32'h12345678, F3_W);
    chk("sw11_err", 32'(got_err), 32'h1); chk("sw11_rd", got_rd, 32'h0);
    txn(0, 32'h13, 32'h0, F3_H);
    chk("lh13_err", 32'(got_err), 32'h1); chk("lh13_rd", got_rd, 32'h0);
    txn(0, 32'h10, 32'h0, 3'b011);
    chk("f3_011_err", 32'(got_err), 32'h1); chk("f3_011_rd", got_rd, 32'h0);
    txn(1, 32'h10, 32'hFFFFFFFF, F3_BU);
    chk("sbu_err", 32'(got_err), 32'h1);
    txn(0, 32'h10, 32'h0, F3_W);   chk("lw10_d", got_rd, 32'hA5AD8001);

    txn(0, 32'h1000, 32'h0, F3_W);
    if (RANGE_CHECK) begin
      chk("range_err", 32'(got_err), 32'h1); chk("range_rd", got_rd, 32'h0);
    end else begin
      chk("alias_err", 32'(got_err), 32'h0); chk("alias_rd", got_rd, 32'hCAFEF00D);
    end

    // Reset during BUSY drops the pending store.
    txn(1, 32'h20, 32'h11111111, F3_W);
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_funct3 = F3_W;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0; #1;
    chk("busy_rst_ready", 32'(req_ready), 32'h0);
    chk("busy_rst_valid", 32'(rsp_valid), 32'h0);
    chk("busy_rst_rdata", rsp_rdata, 32'h0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1; #1;
    chk("release_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", 32'(rsp_valid), 32'h0);
    end
    txn(0, 32'h20, 32'h0, F3_W);   chk("lw20", got_rd, 32'h11111111);

    // Randomized phase over a preloaded 16-word region.
    for (int i = 0; i < 16; i++) txn(1, 32'h100 + 32'(4 * i), $urandom, F3_W);
    for (int i = 0; i < 150; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ra | (32'h1000 << $urandom_range(0, 19));
      txn(1'($urandom_range(0, 1)), ra, $urandom, f3_tab[$urandom_range(0, 9)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's MEM-stage load/store interface. It accepts one request at a time over a valid/ready handshake, waits a configurable number of wait states, and performs the access on a word-organised internal array. Byte, halfword and word accesses are selected by funct3, with lane steering on stores and sign- or zero-extension on loads. It returns data or an error flag as a one-cycle response pulse and replaces the single-cycle DataMem model, so the pipeline can be exercised against multi-cycle memory.

## Interface
- ADDR_WIDTH, 10, word-address bits; array holds 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- WAIT_STATES, 1, extra busy cycles per access; legal range 0..7.

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  access rejected; no array update

## Operation
- States:
  - IDLE: req_ready=1. When req_valid&&req_ready is sampled, the request is captured and the FSM goes to BUSY with the counter set to WAIT_STATES.
  - BUSY: counter decrements each cycle. At the edge where the counter is 0:
    - the array write is committed (if legal);
    - rsp_rdata/rsp_err are registered;
    - the FSM goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Requests are never accepted outside IDLE. req_valid held high while not ready has no effect. Inputs are sampled only at the accept edge.
- Error conditions (rsp_err=1, rsp_rdata=0, array unchanged):
  - funct3 in {011,110,111};
  - store with funct3 100/101;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - range violation (see Configuration).
- Stores:
  - byte enables derive from funct3 and addr[1:0];
  - wdata is replicated into the selected lanes;
  - unselected bytes are preserved.
- Loads:
  - the word is read at index addr[ADDR_WIDTH+1:2];
  - the lane is extracted by addr[1:0];
  - B/H are sign-extended, BU/HU zero-extended.
- A load issued right after a store to the same word returns the new data.

## Timing
- Reset (async assert, sync release through FSM): state IDLE, counter 0, req_ready=0 while reset is low, rsp_valid=0, rsp_rdata=0, rsp_err=0. Array contents are not cleared.
- Accept at edge k: rsp_valid is high from edge k+WAIT_STATES+1 to edge k+WAIT_STATES+2.
- Store data is visible in the array from edge k+WAIT_STATES+1.
- rsp_rdata/rsp_err hold their values after RESP until the next response.
- Minimum request spacing is WAIT_STATES+3 cycles.
- Reset asserted during BUSY: the pending store is dropped and no rsp_valid is issued.
- Reset asserted during RESP: rsp_valid drops immediately.

## Configuration
- DMEM_RANGE_CHECK_EN defined: any nonzero bit in addr[31:ADDR_WIDTH+2] raises rsp_err and suppresses the access.
- Undefined: upper address bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2) bytes.
- Width and alignment errors apply in both builds.

## Structure
- Package dmem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - FSM state typedef {IDLE, BUSY, RESP};
  - MAX_WAIT_STATES=7.
- One combinational sub-module, dmem_lane_align, computes:
  - byte enables and replicated store data;
  - load lane extraction and extension;
  - the alignment/width error flag.
- The FSM, counter and array stay in dmem_responder.

## Test plan
All scenarios use WAIT_STATES=1 and ADDR_WIDTH=10.
- SW 0x10 data 0xDEADBEEF accepted at edge k → rsp_valid at edge k+2, rsp_err=0. Then LW 0x10 → rsp_rdata 0xDEADBEEF.
- SB 0x13 data 0x000000A5 → LB 0x13 = 0xFFFFFFA5, LBU 0x13 = 0x000000A5, LW 0x10 = 0xA5ADBEEF.
- SH 0x10 data 0x00008001 → LH 0x10 = 0xFFFF8001, LHU 0x10 = 0x00008001, LW 0x10 = 0xA5AD8001.
- SW 0x11, LH 0x13, and funct3=011 each → rsp_err=1, rsp_rdata=0; a following LW 0x10 still returns 0xA5AD8001.
- With DMEM_RANGE_CHECK_EN, LW 0x1000 → rsp_err=1. Without it, LW 0x1000 returns the word at 0x0.
- SW 0x20 0x11111111 completes. Then SW 0x20 0x22222222 with reset pulsed low during BUSY → no rsp_valid, req_ready=0 during reset and 1 on the first cycle after release. LW 0x20 returns 0x11111111.
